// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised single-clock FIFO with occupancy count and thresholds
module fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             pop_ok, push_ok;

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != DEPTH_C) || pop_ok);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = push && !push_ok;
    udf_d   = pop && !pop_ok;
    if (push_ok) begin
      wp_d = (wp_q == LAST_P) ? '0 : wp_q + PW'(1);
    end
    if (pop_ok) begin
      rp_d   = (rp_q == LAST_P) ? '0 : rp_q + PW'(1);
      dout_d = mem_q[rp_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wp_q] <= data_in;
    end
  end

  assign data_out     = dout_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign fifo_full    = (count_q == DEPTH_C);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - bench for fifo_param at DEPTH=8 and DEPTH=5
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] dout8, dout5;
  logic        full8, empty8, af8, ae8, ovf8, udf8;
  logic        full5, empty5, af5, ae5, ovf5, udf5;
  logic [3:0]  cnt8;
  logic [2:0]  cnt5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_param #(.WIDTH(16), .DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .data_in(din), .push(push), .pop(pop),
    .data_out(dout8), .fifo_full(full8), .fifo_empty(empty8),
    .almost_full(af8), .almost_empty(ae8), .count(cnt8),
    .overflow(ovf8), .underflow(udf8)
  );

  fifo_param #(.WIDTH(16), .DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .data_in(din), .push(push), .pop(pop),
    .data_out(dout5), .fifo_full(full5), .fifo_empty(empty5),
    .almost_full(af5), .almost_empty(ae5), .count(cnt5),
    .overflow(ovf5), .underflow(udf5)
  );

  // Scoreboards: words expected to come out, in order, per instance.
  logic [15:0] sb8[$];
  logic [15:0] sb5[$];
  int          mc8 = 0, mc5 = 0;
  logic [15:0] md8 = '0, md5 = '0;
  logic        mo8 = 0, mu8 = 0, mo5 = 0, mu5 = 0;

  typedef struct {
    logic        push;
    logic        pop;
    logic [15:0] din;
    int          cnt;
    logic        full, empty, af, ae, ovf, udf;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model8(input logic p, input logic q, input logic [15:0] d, input logic r);
    logic pok, wok;
    if (r) begin
      sb8.delete(); mc8 = 0; md8 = '0; mo8 = 0; mu8 = 0;
    end else begin
      pok = q && (mc8 != 0);
      wok = p && ((mc8 != 8) || pok);
      if (pok) md8 = sb8.pop_front();
      if (wok) sb8.push_back(d);
      mc8 = mc8 + int'(wok) - int'(pok);
      mo8 = p && !wok;
      mu8 = q && !pok;
    end
  endtask

  task automatic model5(input logic p, input logic q, input logic [15:0] d, input logic r);
    logic pok, wok;
    if (r) begin
      sb5.delete(); mc5 = 0; md5 = '0; mo5 = 0; mu5 = 0;
    end else begin
      pok = q && (mc5 != 0);
      wok = p && ((mc5 != 5) || pok);
      if (pok) md5 = sb5.pop_front();
      if (wok) sb5.push_back(d);
      mc5 = mc5 + int'(wok) - int'(pok);
      mo5 = p && !wok;
      mu5 = q && !pok;
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [15:0] d, input logic r);
    push = p; pop = q; din = d; rst = r;
    @(posedge clk);
    #1;
    model8(p, q, d, r);
    model5(p, q, d, r);
    chk("d8_count", 32'(cnt8), 32'(mc8));
    chk("d8_full", 32'(full8), 32'(mc8 == 8));
    chk("d8_empty", 32'(empty8), 32'(mc8 == 0));
    chk("d8_af", 32'(af8), 32'(mc8 >= 6));
    chk("d8_ae", 32'(ae8), 32'(mc8 <= 2));
    chk("d8_dout", 32'(dout8), 32'(md8));
    chk("d8_ovf", 32'(ovf8), 32'(mo8));
    chk("d8_udf", 32'(udf8), 32'(mu8));
    chk("d5_count", 32'(cnt5), 32'(mc5));
    chk("d5_full", 32'(full5), 32'(mc5 == 5));
    chk("d5_empty", 32'(empty5), 32'(mc5 == 0));
    chk("d5_af", 32'(af5), 32'(mc5 >= 3));
    chk("d5_ae", 32'(ae5), 32'(mc5 <= 2));
    chk("d5_dout", 32'(dout5), 32'(md5));
    chk("d5_ovf", 32'(ovf5), 32'(mo5));
    chk("d5_udf", 32'(udf5), 32'(mu5));
  endtask

  initial begin
    vec_t v;
    // Fill / overflow / drain / underflow table for the DEPTH=8 instance.
    for (int i = 1; i <= 8; i++) begin
      v = '{push: 1'b1, pop: 1'b0, din: 16'(i), cnt: i, full: (i == 8), empty: 1'b0,
            af: (i >= 6), ae: (i <= 2), ovf: 1'b0, udf: 1'b0, dout: 16'h0000};
      vecs.push_back(v);
    end
    v = '{push: 1'b1, pop: 1'b0, din: 16'h0009, cnt: 8, full: 1'b1, empty: 1'b0,
          af: 1'b1, ae: 1'b0, ovf: 1'b1, udf: 1'b0, dout: 16'h0000};
    vecs.push_back(v);
    for (int i = 1; i <= 8; i++) begin
      v = '{push: 1'b0, pop: 1'b1, din: 16'h0000, cnt: 8 - i, full: 1'b0, empty: (i == 8),
            af: ((8 - i) >= 6), ae: ((8 - i) <= 2), ovf: 1'b0, udf: 1'b0, dout: 16'(i)};
      vecs.push_back(v);
    end
    v = '{push: 1'b0, pop: 1'b1, din: 16'h0000, cnt: 0, full: 1'b0, empty: 1'b1,
          af: 1'b0, ae: 1'b1, ovf: 1'b0, udf: 1'b1, dout: 16'h0008};
    vecs.push_back(v);
    v = '{push: 1'b0, pop: 1'b0, din: 16'h0000, cnt: 0, full: 1'b0, empty: 1'b1,
          af: 1'b0, ae: 1'b1, ovf: 1'b0, udf: 1'b0, dout: 16'h0008};
    vecs.push_back(v);

    // Reset state
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("rst_count", 32'(cnt8), 32'd0);
    chk("rst_empty", 32'(empty8), 32'd1);
    chk("rst_full", 32'(full8), 32'd0);
    chk("rst_dout", 32'(dout8), 32'd0);
    chk("rst_ovf_udf", {30'd0, ovf8, udf8}, 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din, 1'b0);
      chk("tbl_count", 32'(cnt8), 32'(vecs[i].cnt));
      chk("tbl_flags", {26'd0, full8, empty8, af8, ae8, ovf8, udf8},
          {26'd0, vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].udf});
      chk("tbl_dout", 32'(dout8), 32'(vecs[i].dout));
    end

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0010 + 16'(i), 1'b0);
    step(1'b1, 1'b1, 16'hAAAA, 1'b0);
    chk("fullpp_dout", 32'(dout8), 32'h0010);
    chk("fullpp_count", 32'(cnt8), 32'd8);
    chk("fullpp_ovf", 32'(ovf8), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    chk("fullpp_last", 32'(dout8), 32'hAAAA);

    // Push into empty with simultaneous pop: push lands, pop rejected
    step(1'b1, 1'b1, 16'h0BEE, 1'b0);
    chk("emptypp_udf", 32'(udf8), 32'd1);
    chk("emptypp_count", 32'(cnt8), 32'd1);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    chk("emptypp_dout", 32'(dout8), 32'h0BEE);

    // Wrap-around: alternate push and push+pop for 20 cycles, then drain
    for (int i = 0; i < 20; i++) step(1'b1, (i % 2) == 1, 16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    chk("wrap_empty8", 32'(empty8), 32'd1);
    chk("wrap_empty5", 32'(empty5), 32'd1);

    // Random mixed traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);

    // Reset mid-operation with push and pop asserted
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0);
    chk("pre_rst_count", 32'(cnt8), 32'd5);
    step(1'b1, 1'b1, 16'h5555, 1'b1);
    chk("midrst_count", 32'(cnt8), 32'd0);
    chk("midrst_empty", 32'(empty8), 32'd1);
    chk("midrst_dout", 32'(dout8), 32'd0);
    step(1'b1, 1'b0, 16'h0777, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    chk("postrst_dout", 32'(dout8), 32'h0777);
    chk("postrst_empty", 32'(empty8), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
